store_commit_unit: RTL and testbench
====================================

// Module: store_commit_unit
// PURPOSE
//  Downstream drain stage of the store buffer. Watches the buffer head entry and waits until it is
//  valid, non-speculative and has both address and data tags resolved. It then writes the entry to
//  data RAM with byte enables, and echoes the committed addr/data back on
//  store_addr_active/store_data_active so the buffer clears and compacts that entry.
//  Exactly one store is in flight at a time.
// PARAMETERS
//  ADDR_WIDTH  15  byte address width of data RAM (32 KiB)
//  DATA_WIDTH  32  store data width
//  CNT_WIDTH   16  width of commit_count
// PORTS
//  clk                clock
//  reset              synchronous, active-high; clock clk
//  head_valid         in   1           buffer head slot holds a live entry
//  head_speculative   in   1           head still under an unresolved branch
//  head_addr_tag      in   1           1 = address field is still a tag
//  head_data_tag      in   1           1 = data field is still a tag
//  head_addr          in   ADDR_WIDTH  resolved byte address (base+imm)
//  head_data          in   DATA_WIDTH  resolved store data
//  head_size          in   2           0=SB 1=SH 2=SW (3 illegal)
//  prediction_failed  in   1           branch squash this cycle
//  mem_req            out  1           write request to data RAM
//  mem_addr           out  ADDR_WIDTH  word-aligned address, low 2 bits = 0
//  mem_wdata          out  DATA_WIDTH  lane-replicated write data
//  mem_be             out  4           byte enables
//  mem_ack            in   1           RAM accepted write (may be same cycle as mem_req)
//  store_addr_active  out  ADDR_WIDTH  committed addr echoed to store buffer
//  store_data_active  out  DATA_WIDTH  committed data echoed to store buffer
//  commit_valid       out  1           1-cycle pulse: store retired
//  misalign_err       out  1           1-cycle pulse: store dropped (misaligned or size 3)
//  busy               out  1           state != IDLE
//  commit_count       out  CNT_WIDTH   retired stores (wraps), misaligned ones excluded
// BEHAVIOUR
//  States: IDLE -> REQ -> RETIRE -> IDLE. IDLE -> ERR -> IDLE on bad alignment.
//  eligible = head_valid & !head_speculative & !head_addr_tag & !head_data_tag & !prediction_failed
//  IDLE: if eligible, latch addr/data/size; aligned -> REQ, else -> ERR. Otherwise stay.
//  Aligned means: size0 any addr; size1 addr[0]==0; size2 addr[1:0]==0; size3 never.
//  REQ: mem_req=1 with latched values, held stable until mem_ack. On mem_ack -> RETIRE.
//    prediction_failed is ignored in REQ: the entry was already non-speculative.
//  RETIRE (1 cycle): store_addr_active/store_data_active = latched addr/data; commit_valid=1;
//    commit_count+=1; -> IDLE. Earliest re-latch is the IDLE cycle after RETIRE,
//    because the buffer compacts on the RETIRE edge.
//  ERR (1 cycle): misalign_err=1; echo latched addr/data as in RETIRE so the buffer still clears
//    the entry; no RAM write; commit_count unchanged; -> IDLE.
//  All other states: store_addr_active = all-ones, store_data_active = all-ones.
//    Addr all-ones is a reserved, never-stored value, so no false buffer clears.
//  mem_be / mem_wdata:
//    SB: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}
//    SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{data[15:0]}}
//    SW: be = 4'hF; wdata = data
//  When mem_req=0: mem_be=0, mem_addr=0, mem_wdata=0.
//  Throughput: 3 cycles per store with zero-wait ack (IDLE, REQ+ack, RETIRE).
//  Reset: state=IDLE, mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, commit_valid=0,
//    misalign_err=0, busy=0, commit_count=0, active addr/data = all-ones.
//    Reset mid-REQ drops mem_req on the next edge; the entry is not echoed.
// TESTING
//  SW addr=0x0104 data=0xDEADBEEF, ack next cycle -> mem_addr=0x0104, be=F; commit_valid 1 cycle
//    with active=0x0104/0xDEADBEEF; commit_count=1
//  SB addr=0x0013 data=0x000000AB -> be=4'b1000, wdata=0xABABABAB; SH addr=0x0012 -> be=4'b1100
//  Head speculative=1, or addr_tag=1, or prediction_failed=1 -> mem_req stays 0, busy=0
//    for 10 cycles; clear spec -> mem_req next cycle
//  SW addr=0x0102 -> misalign_err pulse, mem_req never 1, active=0x0102 for 1 cycle,
//    commit_count unchanged
//  mem_ack withheld 5 cycles -> mem_req/addr/be/wdata stable all 5; reset asserted in cycle 3
//    -> mem_req=0 next cycle, no commit_valid
//  Two eligible stores back to back -> second mem_req exactly 3 cycles after first; commit_count=2

Source files
------------

// File: rtl/store_commit_if.sv
// Store commit bus: store-buffer head view, data RAM write port and commit echo.
// The commit unit is the master: it issues RAM writes and retire echoes.
interface store_commit_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  head_valid;
  logic                  head_speculative;
  logic                  head_addr_tag;
  logic                  head_data_tag;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            head_size;
  logic                  prediction_failed;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ack;
  logic [ADDR_WIDTH-1:0] store_addr_active;
  logic [DATA_WIDTH-1:0] store_data_active;
  logic                  commit_valid;
  logic                  misalign_err;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  commit_count;

  modport master (
    input  head_valid, head_speculative, head_addr_tag, head_data_tag,
           head_addr, head_data, head_size, prediction_failed, mem_ack,
    output mem_req, mem_addr, mem_wdata, mem_be,
           store_addr_active, store_data_active, commit_valid, misalign_err,
           busy, commit_count
  );

  modport slave (
    output head_valid, head_speculative, head_addr_tag, head_data_tag,
           head_addr, head_data, head_size, prediction_failed, mem_ack,
    input  mem_req, mem_addr, mem_wdata, mem_be,
           store_addr_active, store_data_active, commit_valid, misalign_err,
           busy, commit_count
  );
endinterface

// File: rtl/store_commit_unit.sv
// Store buffer drain stage: commits the resolved, non-speculative head entry to data RAM
// one store at a time and echoes it back so the buffer can clear and compact the entry.
module store_commit_unit #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic            clk,
  input logic            reset,
  store_commit_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RETIRE = 2'd2, ERR = 2'd3} state_t;

  state_t                state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_next_s;
  logic [DATA_WIDTH-1:0] data_r, data_next_s;
  logic [1:0]            size_r, size_next_s;
  logic                  eligible_s;

  logic                  mem_req_s, mem_req_r;
  logic [ADDR_WIDTH-1:0] mem_addr_s, mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_s, mem_wdata_r;
  logic [3:0]            mem_be_s, mem_be_r;
  logic [ADDR_WIDTH-1:0] act_addr_s, act_addr_r;
  logic [DATA_WIDTH-1:0] act_data_s, act_data_r;
  logic                  commit_valid_s, commit_valid_r;
  logic                  misalign_err_s, misalign_err_r;
  logic                  busy_s, busy_r;
  logic [CNT_WIDTH-1:0]  count_s, count_r;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] low);
    case (size)
      2'd0:    is_aligned = 1'b1;
      2'd1:    is_aligned = ~low[0];
      2'd2:    is_aligned = (low == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] low);
    case (size)
      2'd0:    byte_enable = 4'b0001 << low;
      2'd1:    byte_enable = 4'b0011 << {low[1], 1'b0};
      2'd2:    byte_enable = 4'hF;
      default: byte_enable = 4'h0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [1:0] size,
                                                      input logic [DATA_WIDTH-1:0] d);
    case (size)
      2'd0:    lane_data = {4{d[7:0]}};
      2'd1:    lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  assign eligible_s = bus.head_valid & ~bus.head_speculative & ~bus.head_addr_tag &
                      ~bus.head_data_tag & ~bus.prediction_failed;

  // Next-state and head-entry capture; squash only matters before the entry is latched.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = addr_r;
    data_next_s  = data_r;
    size_next_s  = size_r;
    case (state_r)
      IDLE: begin
        if (eligible_s) begin
          addr_next_s  = bus.head_addr;
          data_next_s  = bus.head_data;
          size_next_s  = bus.head_size;
          state_next_s = is_aligned(bus.head_size, bus.head_addr[1:0]) ? REQ : ERR;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_next_s = RETIRE;
        end else begin
          state_next_s = REQ;
        end
      end
      RETIRE:  state_next_s = IDLE;
      ERR:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and latched store entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      data_r  <= {DATA_WIDTH{1'b0}};
      size_r  <= 2'd0;
    end else begin
      state_r <= state_next_s;
      addr_r  <= addr_next_s;
      data_r  <= data_next_s;
      size_r  <= size_next_s;
    end
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    mem_req_s      = 1'b0;
    mem_addr_s     = {ADDR_WIDTH{1'b0}};
    mem_wdata_s    = {DATA_WIDTH{1'b0}};
    mem_be_s       = 4'h0;
    act_addr_s     = {ADDR_WIDTH{1'b1}};
    act_data_s     = {DATA_WIDTH{1'b1}};
    commit_valid_s = 1'b0;
    misalign_err_s = 1'b0;
    count_s        = count_r;
    case (state_next_s)
      REQ: begin
        mem_req_s   = 1'b1;
        mem_addr_s  = {addr_next_s[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_s = lane_data(size_next_s, data_next_s);
        mem_be_s    = byte_enable(size_next_s, addr_next_s[1:0]);
      end
      RETIRE: begin
        act_addr_s     = addr_next_s;
        act_data_s     = data_next_s;
        commit_valid_s = 1'b1;
        count_s        = count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      ERR: begin
        act_addr_s     = addr_next_s;
        act_data_s     = data_next_s;
        misalign_err_s = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
    busy_s = (state_next_s != IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_r      <= 1'b0;
      mem_addr_r     <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r    <= {DATA_WIDTH{1'b0}};
      mem_be_r       <= 4'h0;
      act_addr_r     <= {ADDR_WIDTH{1'b1}};
      act_data_r     <= {DATA_WIDTH{1'b1}};
      commit_valid_r <= 1'b0;
      misalign_err_r <= 1'b0;
      busy_r         <= 1'b0;
      count_r        <= {CNT_WIDTH{1'b0}};
    end else begin
      mem_req_r      <= mem_req_s;
      mem_addr_r     <= mem_addr_s;
      mem_wdata_r    <= mem_wdata_s;
      mem_be_r       <= mem_be_s;
      act_addr_r     <= act_addr_s;
      act_data_r     <= act_data_s;
      commit_valid_r <= commit_valid_s;
      misalign_err_r <= misalign_err_s;
      busy_r         <= busy_s;
      count_r        <= count_s;
    end
  end

  assign bus.mem_req           = mem_req_r;
  assign bus.mem_addr          = mem_addr_r;
  assign bus.mem_wdata         = mem_wdata_r;
  assign bus.mem_be            = mem_be_r;
  assign bus.store_addr_active = act_addr_r;
  assign bus.store_data_active = act_data_r;
  assign bus.commit_valid      = commit_valid_r;
  assign bus.misalign_err      = misalign_err_r;
  assign bus.busy              = busy_r;
  assign bus.commit_count      = count_r;
endmodule

// File: tb/tb_store_commit_unit.sv
// Scoreboard bench for store_commit_unit: stimulus pushes expected RAM writes and commit
// echoes into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_store_commit_unit;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_commit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  store_commit_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            err;
  } cm_t;

  wr_t exp_wr[$];
  cm_t exp_cm[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input bit v, input bit spec, input bit atag, input bit dtag,
                          input bit pf, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] sz);
    bus.head_valid        = v;
    bus.head_speculative  = spec;
    bus.head_addr_tag     = atag;
    bus.head_data_tag     = dtag;
    bus.prediction_failed = pf;
    bus.head_addr         = a;
    bus.head_data         = d;
    bus.head_size         = sz;
  endtask

  task automatic expect_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [3:0] be, input logic [DW-1:0] wd, input bit err);
    wr_t w;
    cm_t c;
    if (!err) begin
      w.addr  = {a[AW-1:2], 2'b00};
      w.be    = be;
      w.wdata = wd;
      exp_wr.push_back(w);
    end
    c.addr = a;
    c.data = d;
    c.err  = err;
    exp_cm.push_back(c);
  endtask

  // Drives mem_ack after ack_wait request cycles and waits for the retire/error pulse.
  task automatic finish_store(input bit exp_err, input int ack_wait, output int first_req);
    int            req_seen = 0;
    bit            done = 1'b0;
    logic [AW-1:0] a0;
    logic [3:0]    b0;
    logic [DW-1:0] w0;
    first_req = -1;
    for (int n = 1; n <= 40 && !done; n++) begin
      tick();
      if (bus.mem_req) begin
        req_seen++;
        if (req_seen == 1) begin
          first_req = n;
          a0 = bus.mem_addr;
          b0 = bus.mem_be;
          w0 = bus.mem_wdata;
        end else begin
          check("req_hold", 64'({bus.mem_addr, bus.mem_be, bus.mem_wdata}), 64'({a0, b0, w0}));
        end
        if (req_seen > ack_wait) bus.mem_ack = 1'b1;
      end
      if (bus.commit_valid || bus.misalign_err) begin
        bus.head_valid = 1'b0;
        bus.mem_ack    = 1'b0;
        done           = 1'b1;
      end
    end
    check("store_done", 64'(done), 64'(1));
    if (exp_err) check("err_no_req", 64'(req_seen), 64'(0));
    else exp_count++;
    tick();
    check("commit_count", 64'(bus.commit_count), 64'(exp_count));
    check("busy_idle", 64'(bus.busy), 64'(0));
  endtask

  task automatic run_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] sz,
                           input logic [3:0] be, input logic [DW-1:0] wd, input bit err,
                           input int ack_wait);
    int fr;
    expect_store(a, d, be, wd, err);
    set_head(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, d, sz);
    finish_store(err, ack_wait, fr);
  endtask

  // Monitor: pops the scoreboard on RAM handshakes and retire/error pulses.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 64'(1), 64'(0));
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
          check("wr_be", 64'(bus.mem_be), 64'(e.be));
          check("wr_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
        end
      end
      if (!bus.mem_req)
        check("idle_bus_zero", 64'({bus.mem_addr, bus.mem_be, bus.mem_wdata}), 64'(0));
      if (bus.commit_valid || bus.misalign_err) begin
        if (exp_cm.size() == 0) begin
          check("unexpected_commit", 64'(1), 64'(0));
        end else begin
          cm_t c;
          c = exp_cm.pop_front();
          check("cm_kind", 64'({bus.commit_valid, bus.misalign_err}),
                64'(c.err ? 2'b01 : 2'b10));
          check("cm_addr", 64'(bus.store_addr_active), 64'(c.addr));
          check("cm_data", 64'(bus.store_data_active), 64'(c.data));
        end
      end else begin
        check("active_ones", 64'({bus.store_addr_active, bus.store_data_active}),
              64'({{AW{1'b1}}, {DW{1'b1}}}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fr;
    int r1;
    int r2;
    int commits;
    bit prev;
    reset       = 1'b1;
    bus.mem_ack = 1'b0;
    set_head(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 32'h0, 2'd0);
    tick();
    tick();
    check("rst_mem", 64'({bus.mem_req, bus.mem_be, bus.mem_addr, bus.mem_wdata}), 64'(0));
    check("rst_flags", 64'({bus.commit_valid, bus.misalign_err, bus.busy}), 64'(0));
    check("rst_count", 64'(bus.commit_count), 64'(0));
    check("rst_active", 64'({bus.store_addr_active, bus.store_data_active}),
          64'({{AW{1'b1}}, {DW{1'b1}}}));
    reset = 1'b0;
    tick();

    // Directed stores: SW, SB, SH, SB lane 1.
    run_store(15'h0104, 32'hDEADBEEF, 2'd2, 4'hF,    32'hDEADBEEF, 1'b0, 1);
    run_store(15'h0013, 32'h000000AB, 2'd0, 4'b1000, 32'hABABABAB, 1'b0, 0);
    run_store(15'h0012, 32'h0000CAFE, 2'd1, 4'b1100, 32'hCAFECAFE, 1'b0, 0);
    run_store(15'h0021, 32'h12345678, 2'd0, 4'b0010, 32'h78787878, 1'b0, 2);

    // Ineligible head: addr tag, data tag, squash, then speculative released.
    expect_store(15'h0200, 32'h11223344, 4'hF, 32'h11223344, 1'b0);
    for (int v = 0; v < 4; v++) begin
      set_head(1'b1, v == 3, v == 0, v == 1, v == 2, 15'h0200, 32'h11223344, 2'd2);
      for (int n = 0; n < 10; n++) begin
        tick();
        check("blocked", 64'({bus.mem_req, bus.busy}), 64'(0));
      end
    end
    bus.head_speculative = 1'b0;
    finish_store(1'b0, 0, fr);
    check("req_next_cycle", 64'(fr), 64'(1));

    // Misaligned and illegal-size stores are dropped with an error echo.
    run_store(15'h0102, 32'h0BADF00D, 2'd2, 4'h0, 32'h0, 1'b1, 0);
    run_store(15'h0011, 32'h00005555, 2'd1, 4'h0, 32'h0, 1'b1, 0);
    run_store(15'h0100, 32'h77777777, 2'd3, 4'h0, 32'h0, 1'b1, 0);

    // Ack withheld for 5 request cycles.
    run_store(15'h0046, 32'hA5A51234, 2'd1, 4'b1100, 32'h12341234, 1'b0, 5);

    // Reset during the third request cycle: request drops, nothing retires.
    set_head(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0400, 32'h55AA55AA, 2'd2);
    fr = 0;
    for (int n = 0; n < 10 && fr < 3; n++) begin
      tick();
      if (bus.mem_req) fr++;
    end
    check("stall_req_cycles", 64'(fr), 64'(3));
    reset          = 1'b1;
    bus.head_valid = 1'b0;
    tick();
    check("rst_drop_req", 64'({bus.mem_req, bus.commit_valid}), 64'(0));
    reset     = 1'b0;
    exp_count = 0;
    tick();
    check("rst_count_clear", 64'(bus.commit_count), 64'(0));

    // Back-to-back stores with zero-wait ack.
    expect_store(15'h0300, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0);
    expect_store(15'h0305, 32'h000000EE, 4'b0010, 32'hEEEEEEEE, 1'b0);
    bus.mem_ack = 1'b1;
    set_head(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0300, 32'hCAFEF00D, 2'd2);
    r1 = -1;
    r2 = -1;
    commits = 0;
    prev = 1'b0;
    for (int n = 0; n < 40 && commits < 2; n++) begin
      tick();
      if (bus.mem_req && !prev) begin
        if (r1 < 0) r1 = cyc;
        else r2 = cyc;
      end
      prev = bus.mem_req;
      if (bus.commit_valid) begin
        commits++;
        if (commits == 1) set_head(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0305, 32'h000000EE, 2'd0);
        else bus.head_valid = 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
    exp_count += 2;
    check("b2b_commits", 64'(commits), 64'(2));
    check("b2b_spacing", 64'(r2 - r1), 64'(3));
    tick();
    check("b2b_count", 64'(bus.commit_count), 64'(exp_count));

    tick();
    tick();
    check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
    check("cm_queue_empty", 64'(exp_cm.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
